// File: rtl/shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mul
// Description : Iterative unsigned shift-and-add multiplier. Accepts a pair
//               of BW-bit operands, spends BW cycles accumulating partial
//               products, then presents a 2*BW-bit registered product with a
//               one-cycle valid pulse.
//               Optional macro SHIFT_ADD_MUL_ZERO_SKIP_EN: a zero operand
//               completes in one cycle without entering BUSY.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul #(
  parameter int BW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inval,
  input  logic [BW-1:0]   inA,
  input  logic [BW-1:0]   inB,
  output logic [2*BW-1:0] mulout,
  output logic            outval,
  output logic            mulStarted
);

  localparam int            CW         = $clog2(BW + 1);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(BW);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*BW-1:0] r_mcand;
  logic [BW-1:0]   r_mplier;
  logic [2*BW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [2*BW-1:0] r_mulout;
  logic            r_outval;

  logic            w_accept;
  logic            w_last;
  logic            w_zero_skip;
  logic [2*BW-1:0] w_acc_nxt;

  // Zero-operand shortcut: only meaningful when the feature is compiled in.
`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
  assign w_zero_skip = (inA == '0) || (inB == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  assign w_accept  = (r_state == S_IDLE) && inval;
  assign w_last    = (r_state == S_BUSY) && (r_cnt == C_CNT_LAST);
  // Partial-product step: add the shifted multiplicand when the current
  // multiplier bit is set. The final step's sum goes straight to mulout.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign mulout     = r_mulout;
  assign outval     = r_outval;
  assign mulStarted = (r_state == S_BUSY);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> BUSY on a non-skipped accept, BUSY -> IDLE on the last step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_zero_skip) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iterative accumulate, and result/pulse registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mulout <= '0;
      r_outval <= 1'b0;
    end else begin
      r_outval <= 1'b0;
      if (w_accept) begin
        if (w_zero_skip) begin
          r_mulout <= '0;
          r_outval <= 1'b1;
        end else begin
          r_mcand  <= {{BW{1'b0}}, inA};
          r_mplier <= inB;
          r_acc    <= '0;
          r_cnt    <= C_CNT_LOAD;
        end
      end else if (r_state == S_BUSY) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - C_CNT_LAST;
        if (w_last) begin
          r_mulout <= w_acc_nxt;
          r_outval <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mul
// Description : Self-checking bench for shift_add_mul. A cycle model queues
//               the expected product at each accept; the output monitor pops
//               and compares on every outval pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul;

  localparam int BW = 4;
  localparam int PW = 2 * BW;
`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          inval;
  logic [BW-1:0] inA;
  logic [BW-1:0] inB;
  logic [PW-1:0] mulout;
  logic          outval;
  logic          mulStarted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] sb[$];
  bit            m_busy   = 1'b0;
  int            m_left   = 0;
  bit            m_outval = 1'b0;
  logic [PW-1:0] m_mulout = '0;

  always #5 clk = ~clk;

  shift_add_mul #(.BW(BW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .inval      (inval),
    .inA        (inA),
    .inB        (inB),
    .mulout     (mulout),
    .outval     (outval),
    .mulStarted (mulStarted)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Cycle model: tracks busy timing and pushes the expected product at each accept.
  always @(posedge clk) begin
    m_outval = 1'b0;
    if (rstn !== 1'b1) begin
      m_busy   = 1'b0;
      m_left   = 0;
      m_mulout = '0;
      sb.delete();
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy   = 1'b0;
        m_outval = 1'b1;
      end
    end else if (inval) begin
      if (ZS && (inA == '0 || inB == '0)) begin
        sb.push_back('0);
        m_outval = 1'b1;
      end else begin
        sb.push_back(PW'(inA) * PW'(inB));
        m_busy = 1'b1;
        m_left = BW;
      end
    end
  end

  // Output monitor: compare status every cycle, pop the scoreboard on each result.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    check("mulStarted", PW'(mulStarted), PW'(m_busy));
    check("outval", PW'(outval), PW'(m_outval));
    if (outval === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $error("FAIL sb_underflow: observed outval=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        m_mulout = e;
        check("product", mulout, e);
      end
    end
    check("mulout_hold", mulout, m_mulout);
  end

  // One operation from IDLE; junk operands with inval=1 while busy must be ignored.
  task automatic op(input logic [BW-1:0] a, input logic [BW-1:0] b);
    bit skip;
    skip  = ZS && (a == '0 || b == '0);
    inval = 1'b1;
    inA   = a;
    inB   = b;
    @(negedge clk);
    repeat (BW) begin
      inval = !skip;
      inA   = BW'($urandom);
      inB   = BW'($urandom);
      @(negedge clk);
    end
    inval = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset with inval asserted: must be ignored.
    rstn  = 1'b0;
    inval = 1'b1;
    inA   = 4'd7;
    inB   = 4'd7;
    repeat (3) @(negedge clk);
    check("reset_mulout", mulout, '0);
    check("reset_busy", PW'(mulStarted), '0);

    // First accept at the first edge with rstn high: 3*5.
    rstn  = 1'b1;
    inval = 1'b1;
    inA   = 4'd3;
    inB   = 4'd5;
    @(negedge clk);
    inval = 1'b0;
    repeat (BW + 1) @(negedge clk);
    check("directed_3x5", mulout, PW'(15));

    op(4'd15, 4'd15);
    check("directed_15x15", mulout, PW'(225));
    op(4'd15, 4'd1);
    check("directed_15x1", mulout, PW'(15));
    op(4'd1, 4'd15);
    check("directed_1x15", mulout, PW'(15));

    // Back-to-back: inval held high with fresh operands every cycle.
    for (int i = 0; i < 20; i++) begin
      inval = 1'b1;
      inA   = BW'($urandom);
      inB   = BW'($urandom);
      @(negedge clk);
    end
    inval = 1'b0;
    repeat (BW + 2) @(negedge clk);

    // Reset during the 2nd busy cycle of 7*9 aborts the operation.
    inval = 1'b1;
    inA   = 4'd7;
    inB   = 4'd9;
    @(negedge clk);
    inval = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (BW + 1) @(negedge clk);
    check("abort_mulout", mulout, '0);
    check("abort_busy", PW'(mulStarted), '0);
    op(4'd2, 4'd3);
    check("directed_2x3", mulout, PW'(6));

    // Zero operands.
    op(4'd5, 4'd5);
    op(4'd0, 4'd9);
    check("zero_0x9", mulout, '0);
    op(4'd5, 4'd5);
    op(4'd6, 4'd0);
    check("zero_6x0", mulout, '0);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      inval = 1'($urandom_range(0, 1));
      inA   = BW'($urandom);
      inB   = BW'($urandom);
      @(negedge clk);
    end
    inval = 1'b0;
    repeat (BW + 2) @(negedge clk);
    check("sb_drained", PW'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter: BW, default 4, operand width in bits; SHALL be >= 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 inval  input  1  operand-valid strobe; request to start a multiply.
REQ-005 inA  input  BW  multiplicand, unsigned.
REQ-006 inB  input  BW  multiplier, unsigned.
REQ-007 mulout  output  2*BW  product, unsigned, registered.
REQ-008 outval  output  1  one-cycle pulse marking mulout as a new result.
REQ-009 mulStarted  output  1  busy flag; high while a multiply is in progress, registered.

Function
REQ-010 Two states SHALL exist: IDLE (mulStarted=0) and BUSY (mulStarted=1).
REQ-011 IDLE with inval=1 at a rising edge SHALL capture inA/inB, clear the partial-product accumulator to 0, load an iteration counter with BW, and enter BUSY.
REQ-012 IDLE with inval=0 SHALL hold all state; mulout SHALL keep its last result.
REQ-013 Each BUSY cycle SHALL examine the multiplier LSB: if 1, add the multiplicand, aligned to the current shift position, into the 2*BW-bit accumulator; then shift the multiplicand left one bit and the multiplier right one bit (or the equivalent right-shifting accumulator form), and decrement the counter.
REQ-014 Accumulator and adder SHALL be 2*BW bits; no overflow is possible; arithmetic is unsigned modulo 2^(2*BW).
REQ-015 On the BW-th BUSY cycle, the edge SHALL load mulout with inA*inB, set outval=1, and return to IDLE (mulStarted=0).
REQ-016 Latency: outval SHALL be high in the cycle beginning exactly BW rising edges after the accepting edge; throughput is one multiply per BW+1 cycles.
REQ-017 outval SHALL be high for exactly one cycle per completed multiply and low otherwise.
REQ-018 inval asserted while BUSY SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-019 inval=1 in the cycle outval is high (state IDLE) SHALL be accepted at that edge: back-to-back operation.
REQ-020 mulout SHALL change only at completion edges and reset; intermediate accumulator values SHALL NOT be visible on mulout.

Reset
REQ-021 rstn=0 at a rising edge SHALL force IDLE, mulStarted=0, outval=0, mulout=0, counter=0, accumulator=0.
REQ-022 Reset during BUSY SHALL abort the operation with no outval pulse; inval during reset SHALL be ignored.
REQ-023 The first accept SHALL be possible at the first rising edge with rstn=1.

Configuration
REQ-024 Macro SHIFT_ADD_MUL_ZERO_SKIP_EN: when defined, an accepted operation with inA=0 or inB=0 SHALL skip BUSY, loading mulout=0 and pulsing outval in the cycle right after the accepting edge (latency 1); mulStarted stays 0.
REQ-025 Without SHIFT_ADD_MUL_ZERO_SKIP_EN, zero operands SHALL take the full BW-cycle latency like any other operands.

Verification
REQ-026 BW=4, after reset, inA=3, inB=5, inval pulse -> mulStarted=1 for 4 cycles, then outval=1 one cycle with mulout=15.
REQ-027 inA=15, inB=15 -> mulout=225 (0xE1) after 4 cycles; inA=15, inB=1 -> 15; inA=1, inB=15 -> 15.
REQ-028 inval held high continuously with new operands each IDLE cycle -> accepts at the outval cycle, result every 5 cycles, operand changes while busy have no effect.
REQ-029 rstn=0 for one edge during the 2nd BUSY cycle of 7*9 -> no outval, mulout=0, mulStarted=0; next request 2*3 -> 6.
REQ-030 inA=0, inB=9: without macro -> mulout=0 after 4 cycles; with SHIFT_ADD_MUL_ZERO_SKIP_EN -> mulout=0, outval in the cycle after accept.
REQ-031 Random unsigned operands, 200+ cycles -> every outval has mulout equal to the product of the operands captured at the matching accept.
